// File: rtl/rand_range.sv
// rand_range: reduces LFSR words to integers in [0, lim) by mask-and-reject,
// with a bounded retry count and a subtract fallback on the final try.
module rand_range #(
  parameter int LEN = 16,
  parameter int OUTW = 8,
  parameter int MAX_TRIES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [OUTW-1:0] lim,
  input  logic [LEN-1:0]  rnd,
  output logic            lfsr_en,
  output logic [OUTW-1:0] rnd_data,
  output logic            rnd_valid,
  input  logic            rnd_ready,
  output logic            rnd_forced
);
  localparam int TW = $clog2(MAX_TRIES) + 1;
  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;
  state_t state, state_n;
  logic [TW-1:0] tries;
  logic [OUTW-1:0] lim_q, lim_m1, mask, cand;
  logic accept, last, start, done;
  always_comb begin
    lim_m1 = lim_q - OUTW'(1);
    mask = lim_m1;
    for (int i = 1; i < OUTW; i++) mask = mask | (lim_m1 >> i);
    cand = rnd[LEN-1 -: OUTW] & mask;
    accept = (lim_q == '0) || (cand < lim_q);
    last = tries == TW'(MAX_TRIES - 1);
    lfsr_en = (state == DRAW) && en;
    rnd_valid = state == HOLD;
    start = ((state == IDLE) && en) || ((state == HOLD) && rnd_ready);
    done = lfsr_en && (accept || last);
    state_n = start ? DRAW : done ? HOLD : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tries <= '0;
      lim_q <= '0;
      rnd_data <= '0;
      rnd_forced <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        lim_q <= lim;
        tries <= '0;
      end else if (lfsr_en && !accept) begin
        tries <= tries + TW'(1);
      end
      // mask < 2*lim_q, so a rejected candidate minus lim_q is always in range
      if (done) begin
        rnd_data <= accept ? cand : cand - lim_q;
        rnd_forced <= !accept;
      end
    end
  end
endmodule

// File: tb/tb_rand_range.sv
// tb_rand_range: directed checks of draw, reject, fallback, backpressure,
// enable freeze and async reset, all sampled at the falling edge.
module tb_rand_range;
  logic clk = 0, rst = 1, en = 0, rnd_ready = 0;
  logic [7:0] lim = 0, rnd = 0;
  logic lfsr_en, rnd_valid, rnd_forced;
  logic [7:0] rnd_data;
  int n_cmp = 0, n_bad = 0;

  rand_range #(.LEN(8), .OUTW(8), .MAX_TRIES(4)) dut (
    .clk(clk), .rst(rst), .en(en), .lim(lim), .rnd(rnd),
    .lfsr_en(lfsr_en), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .rnd_forced(rnd_forced)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic out(input string tag, input logic v, input logic [7:0] d, input logic f, input logic l);
    chk({tag, ".valid"}, rnd_valid, v);
    chk({tag, ".data"}, rnd_data, d);
    chk({tag, ".forced"}, rnd_forced, f);
    chk({tag, ".lfsr_en"}, lfsr_en, l);
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    nxt; nxt;
    out("reset", 0, 8'h00, 0, 0);
    rst = 0;
    // full range
    en = 1; lim = 0; rnd = 8'hA5;
    #1 chk("idle_no_lfsr_en", lfsr_en, 0);
    nxt;
    chk("full.draw_lfsr_en", lfsr_en, 1);
    chk("full.draw_valid", rnd_valid, 0);
    nxt;
    out("full.hold", 1, 8'hA5, 0, 0);
    // rejection: lim 10 captured on handshake
    rnd_ready = 1; lim = 10;
    nxt;
    rnd_ready = 0; rnd = 8'h0C;
    #1 chk("rej.valid_drop", rnd_valid, 0);
    chk("rej.lfsr_en0", lfsr_en, 1);
    nxt; rnd = 8'h0F;
    #1 chk("rej.lfsr_en1", lfsr_en, 1);
    chk("rej.valid1", rnd_valid, 0);
    nxt; rnd = 8'h03;
    #1 chk("rej.lfsr_en2", lfsr_en, 1);
    chk("rej.valid2", rnd_valid, 0);
    nxt;
    out("rej.hold", 1, 8'h03, 0, 0);
    // fallback after MAX_TRIES rejects of 0x0E
    rnd_ready = 1;
    nxt;
    rnd_ready = 0; rnd = 8'h0E;
    for (int i = 0; i < 4; i++) begin
      #1 chk("fb.lfsr_en", lfsr_en, 1);
      chk("fb.valid", rnd_valid, 0);
      nxt;
    end
    out("fb.hold", 1, 8'h04, 1, 0);
    // backpressure while lim changes
    for (int i = 0; i < 5; i++) begin
      lim = 8'(i * 37 + 3); rnd = 8'(i * 91);
      #1 out("bp", 1, 8'h04, 1, 0);
      nxt;
    end
    lim = 1; rnd_ready = 1;
    nxt;
    rnd_ready = 0; rnd = 8'hFF; lim = 10;
    #1 chk("lim1.valid_drop", rnd_valid, 0);
    chk("lim1.lfsr_en", lfsr_en, 1);
    nxt;
    out("lim1.hold", 1, 8'h00, 0, 0);
    // en low mid-draw freezes tries
    rnd_ready = 1; lim = 10;
    nxt;
    rnd_ready = 0; rnd = 8'h0E;
    #1 chk("en.first_draw", lfsr_en, 1);
    nxt; en = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("en.frozen_lfsr_en", lfsr_en, 0);
      chk("en.frozen_valid", rnd_valid, 0);
      nxt;
    end
    en = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("en.resume_lfsr_en", lfsr_en, 1);
      chk("en.resume_valid", rnd_valid, 0);
      nxt;
    end
    out("en.hold", 1, 8'h04, 1, 0);
    // async reset during retry 2
    rnd_ready = 1;
    nxt;
    rnd_ready = 0;
    nxt; nxt;
    #2 rst = 1;
    #1 out("rst_retry", 0, 8'h00, 0, 0);
    nxt;
    rst = 0; en = 0; lim = 0; rnd = 8'h5A;
    nxt; nxt;
    out("rst_idle", 0, 8'h00, 0, 0);
    en = 1;
    #1 chk("rst_idle_en_comb", lfsr_en, 0);
    nxt;
    chk("post_rst.lfsr_en", lfsr_en, 1);
    nxt;
    out("post_rst.hold", 1, 8'h5A, 0, 0);
    // async reset during a forced HOLD
    lim = 10; rnd = 8'h0E; rnd_ready = 1;
    nxt;
    rnd_ready = 0;
    nxt; nxt; nxt; nxt;
    out("rst_hold.pre", 1, 8'h04, 1, 0);
    #2 rst = 1;
    #1 out("rst_hold", 0, 8'h00, 0, 0);
    nxt;
    rst = 0;
    nxt;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
